// File: rtl/systolic_skew_feeder.sv
// Skews one edge (A rows or B columns) of an N-lane systolic MAC array into a diagonal wavefront.
// Optional: define FEEDER_PSUM_CLR_EN to pulse psum_clr alongside the first pe_en of each tile.
module systolic_skew_feeder #(
   parameter int N           = 4,
   parameter int DATA_WIDTH  = 16,
   parameter int K_MAX       = 256,
   parameter int FLUSH_STEPS = 2*N-2,
   localparam int KW         = $clog2(K_MAX+1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [N*DATA_WIDTH-1:0] s_data,
   input  logic                    s_last,
   output logic [N*DATA_WIDTH-1:0] lane_data,
   output logic                    pe_en,
   output logic                    busy,
   output logic                    done,
   output logic [KW-1:0]           k_count,
   output logic                    overflow,
   output logic                    psum_clr
);

   // state  | meaning
   // IDLE   | waiting for the first vector of a tile
   // STREAM | accepting vectors, one advance per handshake
   // FLUSH  | inserting zero steps until the wavefront drains
   // DONE   | one-cycle completion pulse, final pe_en is high here

   localparam int FW = (FLUSH_STEPS > 1) ? $clog2(FLUSH_STEPS+1) : 1;
   localparam logic [KW-1:0] KMAX_W = KW'(K_MAX);

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_DONE} state_t;

   state_t          state, state_nxt;
   logic [FW-1:0]   flush_cnt;
   logic            handshake;
   logic            advance;
   logic            tile_end;
   logic            hit_kmax;
   logic [KW-1:0]   k_next;

   assign handshake = s_valid & s_ready;
   assign advance   = handshake | (state == S_FLUSH);

   // First vector of a tile restarts the count; otherwise saturate at K_MAX.
   assign k_next   = (state == S_IDLE) ? KW'(1) :
                     (k_count == KMAX_W) ? k_count : k_count + 1'b1;
   assign hit_kmax = (k_next == KMAX_W);
   assign tile_end = handshake & (s_last | hit_kmax);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            s_ready = 1'b1;
            if (handshake) state_nxt = tile_end ? S_FLUSH : S_STREAM;
         end
         S_STREAM: begin
            s_ready = 1'b1;
            busy    = 1'b1;
            if (tile_end) state_nxt = S_FLUSH;
         end
         S_FLUSH: begin
            busy = 1'b1;
            if (flush_cnt == '0) state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_cnt <= '0;
      end else if (tile_end) begin
         flush_cnt <= FW'(FLUSH_STEPS-1);
      end else if (state == S_FLUSH && flush_cnt != '0) begin
         flush_cnt <= flush_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_count  <= '0;
         overflow <= 1'b0;
         pe_en    <= 1'b0;
      end else begin
         pe_en <= advance;
         if (handshake) begin
            k_count  <= k_next;
            overflow <= (overflow & (state != S_IDLE)) | (hit_kmax & ~s_last);
         end
      end
   end

   // Lane i is i+1 stages deep; the last stage drives the array edge directly.
   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [DATA_WIDTH-1:0] stg [0:i];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int j = 0; j <= i; j++) stg[j] <= '0;
         end else if (advance) begin
            stg[0] <= handshake ? s_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
            for (int j = 1; j <= i; j++) stg[j] <= stg[j-1];
         end
      end

      assign lane_data[i*DATA_WIDTH +: DATA_WIDTH] = stg[i];
   end

`ifdef FEEDER_PSUM_CLR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) psum_clr <= 1'b0;
      else        psum_clr <= handshake & (state == S_IDLE);
   end
`else
   assign psum_clr = 1'b0;
`endif

endmodule
